arb_req_agent: RTL and testbench
================================

# arb_req_agent

Requester-side companion to the round-robin arbiter. It buffers transactions from NUM_PORTS independent sources in per-port FIFOs and presents one request bit per non-empty FIFO to the arbiter. It consumes the arbiter's one-hot grant, pops the granted FIFO and delivers the entry on a single registered valid/ready output stream tagged with its source port. It sits between the client ports and the shared downstream resource, with the arbiter instance alongside.

## Interface
- NUM_PORTS, 4: number of client ports; must equal the arbiter width.
- DATA_W, 8: payload width per entry.
- DEPTH, 4: entries per port FIFO; power of two, at least 2.
- clk  input  1  single clock, rising edge.
- reset_n  input  1  reset; one clock; asynchronous assert, active-low.
- push_valid_i  input  NUM_PORTS  per-port write strobe.
- push_data_i  input  NUM_PORTS*DATA_W  per-port payload; port p occupies bits [p*DATA_W +: DATA_W].
- push_ready_o  output  NUM_PORTS  per-port "FIFO not full".
- req_o  output  NUM_PORTS  request vector to the arbiter.
- gnt_i  input  NUM_PORTS  one-hot grant from the arbiter, combinational from req_o.
- out_valid_o  output  1  output register holds an entry.
- out_data_o  output  DATA_W  payload of the held entry.
- out_port_o  output  $clog2(NUM_PORTS)  source port of the held entry.
- out_ready_i  input  1  downstream accepts the held entry.
- occ_o  output  NUM_PORTS*($clog2(DEPTH)+1)  per-port occupancy, 0..DEPTH.
- err_o  output  1  sticky protocol-error flag.

## Operation
- **Push:** on the edge where push_valid_i[p] & push_ready_o[p], write push_data_i slice p into FIFO p.
  - push_ready_o[p] = (occ[p] != DEPTH).
  - There is no bypass: a full FIFO refuses a push even in a cycle where it pops.
- **Output slot:**
  - slot_free = !out_valid_o | out_ready_i.
  - req_o[p] = slot_free & (occ[p] != 0).
  - When the slot is not free, req_o is all-zero. This keeps the arbiter's mask from advancing on a grant that is not consumed.
- **Grant:**
  - The grant is legal when gnt_i is one-hot and gnt_i & req_o == gnt_i.
  - On a legal grant for port g: pop FIFO g, load out_data_o with its head, load out_port_o = g, and set out_valid_o = 1 on the same edge.
- **Drain:** if out_valid_o & out_ready_i and no legal grant occurs, clear out_valid_o.
- **Illegal grant** (multi-hot, or a bit set where req_o is 0):
  - No pop and no output load.
  - err_o sets and holds until reset.
  - A non-zero gnt_i while req_o == 0 is also illegal.
- **Simultaneous push and pop on one port:** occupancy is unchanged, and head and tail pointers both advance.
- **FIFO storage:**
  - DEPTH-entry circular buffers with $clog2(DEPTH)-bit pointers that wrap modulo DEPTH.
  - Occupancy is held in a separate counter.
- Payload ordering is preserved within a port. The order across ports is set only by the arbiter.

## Timing
- All outputs are registered except req_o and push_ready_o. Those two are combinational from registered state and out_ready_i.
- Reset values:
  - out_valid_o = 0, out_data_o = 0, out_port_o = 0, err_o = 0.
  - All occupancies are 0 and all pointers are 0.
  - req_o = 0 and push_ready_o = all-ones.
- Minimum latency is 2 cycles from push to output:
  - push sampled at edge N;
  - req_o asserted during cycle N..N+1;
  - out_valid_o high after edge N+1.
- Throughput is one entry per cycle when out_ready_i is held high and any FIFO is non-empty.
- Asserting reset mid-operation discards all buffered and held entries immediately (asynchronously). The first push is accepted on the first rising edge after reset_n deasserts.

## Test plan
- **Single entry:** after reset, push 0xA5 on port 2 with out_ready_i=1.
  - req_o = 0100 for one cycle.
  - out_valid_o=1, out_data_o=0xA5, out_port_o=2 two edges after the push.
  - occ_o[2] returns to 0.
- **Round robin, all ports:** preload 2 entries per port (port p holds 0x10+p, then 0x20+p) and hold out_ready_i=1.
  - Output sequence is ports 0,1,2,3,0,1,2,3 on consecutive cycles.
  - Data 0x10..0x13, then 0x20..0x23.
- **Backpressure:** preload ports 0 and 1, then hold out_ready_i=0 for 5 cycles.
  - req_o = 0 and the output is stable for all 5 cycles.
  - No arbiter pointer movement.
  - On release, the remaining entry follows on the next cycle.
- **Full:** push 4 entries on port 3 with the output blocked.
  - push_ready_o[3]=0 and occ=4.
  - A 5th push is ignored.
  - Drain all entries: they emerge in FIFO order, and the pointers wrap correctly on a second fill.
- **Illegal grant:** force gnt_i = 0011 while req_o = 0001.
  - err_o=1 and stays set.
  - No pop: occupancies are unchanged and out_valid_o is unchanged.
- **Reset mid-operation:** pulse reset_n low while 3 FIFOs are non-empty and out_valid_o=1.
  - All outputs return to their reset values immediately.
  - The next push on port 0 after deassert emerges with 2-cycle latency.

Source files
------------

// File: rtl/arb_req_agent.sv
// Requester-side agent for a round-robin arbiter: per-port FIFOs feed a request vector,
// and the granted head is moved into a single registered valid/ready output slot.
module arb_req_agent #(
  parameter int NUM_PORTS = 4,
  parameter int DATA_W    = 8,
  parameter int DEPTH     = 4
) (
  input  logic                                   clk,
  input  logic                                   reset_n,
  input  logic [NUM_PORTS-1:0]                   push_valid_i,
  input  logic [NUM_PORTS*DATA_W-1:0]            push_data_i,
  output logic [NUM_PORTS-1:0]                   push_ready_o,
  output logic [NUM_PORTS-1:0]                   req_o,
  input  logic [NUM_PORTS-1:0]                   gnt_i,
  output logic                                   out_valid_o,
  output logic [DATA_W-1:0]                      out_data_o,
  output logic [$clog2(NUM_PORTS)-1:0]           out_port_o,
  input  logic                                   out_ready_i,
  output logic [NUM_PORTS*($clog2(DEPTH)+1)-1:0] occ_o,
  output logic                                   err_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int IW = $clog2(NUM_PORTS);

  logic                 slot_free;
  logic                 gnt_legal;
  logic                 gnt_illegal;
  logic [IW-1:0]        gnt_idx;
  logic [NUM_PORTS-1:0] push;
  logic [NUM_PORTS-1:0] pop;
  logic [DATA_W-1:0]    head [NUM_PORTS];

  // Requests are withheld while the slot is occupied so the arbiter never
  // advances its mask on a grant that cannot be consumed.
  assign slot_free   = !out_valid_o || out_ready_i;
  assign gnt_legal   = $onehot(gnt_i) && ((gnt_i & ~req_o) == '0);
  assign gnt_illegal = (gnt_i != '0) && !gnt_legal;

  always_comb begin
    gnt_idx = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (gnt_i[i]) gnt_idx = IW'(i);
    end
  end

  for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_port
    logic [DATA_W-1:0] mem [DEPTH];
    logic [PW-1:0]     wr_ptr_reg;
    logic [PW-1:0]     rd_ptr_reg;
    logic [CW-1:0]     occ_reg;

    assign push_ready_o[gi]      = (occ_reg != CW'(DEPTH));
    assign req_o[gi]             = slot_free && (occ_reg != '0);
    assign push[gi]              = push_valid_i[gi] && push_ready_o[gi];
    assign pop[gi]               = gnt_legal && gnt_i[gi];
    assign head[gi]              = mem[rd_ptr_reg];
    assign occ_o[gi*CW +: CW]    = occ_reg;

    // Payload storage carries no reset; occupancy alone defines validity.
    always_ff @(posedge clk) begin
      if (push[gi]) mem[wr_ptr_reg] <= push_data_i[gi*DATA_W +: DATA_W];
    end

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        wr_ptr_reg <= '0;
        rd_ptr_reg <= '0;
        occ_reg    <= '0;
      end else begin
        if (push[gi]) wr_ptr_reg <= wr_ptr_reg + PW'(1);
        if (pop[gi])  rd_ptr_reg <= rd_ptr_reg + PW'(1);
        if (push[gi] && !pop[gi])      occ_reg <= occ_reg + CW'(1);
        else if (pop[gi] && !push[gi]) occ_reg <= occ_reg - CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid_o <= 1'b0;
      out_data_o  <= '0;
      out_port_o  <= '0;
      err_o       <= 1'b0;
    end else begin
      if (gnt_legal) begin
        out_valid_o <= 1'b1;
        out_data_o  <= head[gnt_idx];
        out_port_o  <= gnt_idx;
      end else if (out_valid_o && out_ready_i) begin
        out_valid_o <= 1'b0;
      end
      if (gnt_illegal) err_o <= 1'b1;
    end
  end

endmodule

// File: tb/tb_arb_req_agent.sv
// Directed bench for arb_req_agent with a behavioural round-robin arbiter closing the
// req/gnt loop; the grant can be overridden to inject illegal patterns.
module tb_arb_req_agent;

  logic        clk;
  logic        reset_n;
  logic [3:0]  push_valid;
  logic [31:0] push_data;
  logic [3:0]  push_ready;
  logic [3:0]  req;
  logic [3:0]  gnt;
  logic        out_valid;
  logic [7:0]  out_data;
  logic [1:0]  out_port;
  logic        out_ready;
  logic [11:0] occ;
  logic        err;

  logic        force_en;
  logic [3:0]  force_gnt;
  logic [1:0]  rr_ptr;
  logic [3:0]  arb_gnt;
  logic [1:0]  idx;
  logic        found;

  int n_cmp = 0;
  int n_err = 0;

  arb_req_agent #(.NUM_PORTS(4), .DATA_W(8), .DEPTH(4)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .push_valid_i (push_valid),
    .push_data_i  (push_data),
    .push_ready_o (push_ready),
    .req_o        (req),
    .gnt_i        (gnt),
    .out_valid_o  (out_valid),
    .out_data_o   (out_data),
    .out_port_o   (out_port),
    .out_ready_i  (out_ready),
    .occ_o        (occ),
    .err_o        (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Round-robin arbiter model: first requester at or after rr_ptr wins.
  always_comb begin
    arb_gnt = '0;
    found   = 1'b0;
    idx     = '0;
    for (int k = 0; k < 4; k++) begin
      idx = rr_ptr + 2'(k);
      if (!found && req[idx]) begin
        arb_gnt[idx] = 1'b1;
        found        = 1'b1;
      end
    end
  end

  assign gnt = force_en ? force_gnt : arb_gnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) rr_ptr <= '0;
    else if (!force_en) begin
      for (int k = 0; k < 4; k++) begin
        if (arb_gnt[k]) rr_ptr <= 2'(k + 1);
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  function automatic logic [2:0] occ_of(input int p);
    return occ[p*3 +: 3];
  endfunction

  task automatic do_reset();
    reset_n    = 1'b0;
    push_valid = '0;
    push_data  = '0;
    out_ready  = 1'b0;
    force_en   = 1'b0;
    force_gnt  = '0;
    cyc(2);
    reset_n = 1'b1;
  endtask

  initial begin
    reset_n    = 1'b0;
    push_valid = '0;
    push_data  = '0;
    out_ready  = 1'b0;
    force_en   = 1'b0;
    force_gnt  = '0;
    cyc(2);
    chk("rst_valid", out_valid, 0);
    chk("rst_data", out_data, 0);
    chk("rst_port", out_port, 0);
    chk("rst_err", err, 0);
    chk("rst_req", req, 0);
    chk("rst_pready", push_ready, 4'hF);
    chk("rst_occ", occ, 0);
    reset_n = 1'b1;

    // Single entry on port 2
    push_valid = 4'b0100;
    push_data  = 32'h00A5_0000;
    out_ready  = 1'b1;
    cyc(1);
    push_valid = '0;
    chk("t1_req", req, 4'b0100);
    chk("t1_occ2", occ_of(2), 1);
    chk("t1_valid_early", out_valid, 0);
    cyc(1);
    chk("t1_valid", out_valid, 1);
    chk("t1_data", out_data, 8'hA5);
    chk("t1_port", out_port, 2);
    chk("t1_occ2_empty", occ_of(2), 0);
    chk("t1_req_idle", req, 0);
    cyc(1);
    chk("t1_drained", out_valid, 0);

    // Round robin across all ports, two entries each
    do_reset();
    out_ready  = 1'b1;
    push_valid = 4'hF;
    push_data  = 32'h1312_1110;
    cyc(1);
    push_data  = 32'h2322_2120;
    chk("t2_req", req, 4'hF);
    cyc(1);
    push_valid = '0;
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("t2_valid%0d", k), out_valid, 1);
      chk($sformatf("t2_port%0d", k), out_port, k % 4);
      chk($sformatf("t2_data%0d", k), out_data, (k < 4 ? 8'h10 : 8'h20) + 8'(k % 4));
      cyc(1);
    end
    chk("t2_drained", out_valid, 0);
    chk("t2_occ", occ, 0);

    // Backpressure with ports 0 and 1 loaded
    do_reset();
    push_valid = 4'b0011;
    push_data  = 32'h0000_3130;
    cyc(1);
    push_valid = '0;
    chk("t3_req", req, 4'b0011);
    cyc(1);
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("t3_req_hold%0d", i), req, 0);
      chk($sformatf("t3_valid_hold%0d", i), out_valid, 1);
      chk($sformatf("t3_data_hold%0d", i), out_data, 8'h30);
      chk($sformatf("t3_port_hold%0d", i), out_port, 0);
      chk($sformatf("t3_occ1_hold%0d", i), occ_of(1), 1);
      cyc(1);
    end
    out_ready = 1'b1;
    #1;
    chk("t3_req_release", req, 4'b0010);
    cyc(1);
    chk("t3_valid_next", out_valid, 1);
    chk("t3_data_next", out_data, 8'h31);
    chk("t3_port_next", out_port, 1);
    cyc(1);
    chk("t3_drained", out_valid, 0);

    // Fill port 3 while the slot is blocked by a port-0 entry
    out_ready  = 1'b0;
    push_valid = 4'b0001;
    push_data  = 32'h0000_0040;
    cyc(1);
    push_valid = 4'b1000;
    push_data  = 32'h5000_0000;
    cyc(1);
    chk("t4_block_valid", out_valid, 1);
    chk("t4_block_data", out_data, 8'h40);
    for (int j = 1; j < 4; j++) begin
      push_data = {8'(8'h50 + j), 24'h0};
      cyc(1);
    end
    chk("t4_occ3_full", occ_of(3), 4);
    chk("t4_pready3", push_ready[3], 0);
    chk("t4_req_blocked", req, 0);
    push_data = 32'h5400_0000;
    cyc(1);
    chk("t4_occ3_5th", occ_of(3), 4);
    push_valid = '0;
    out_ready  = 1'b1;
    cyc(1);
    for (int j = 0; j < 4; j++) begin
      chk($sformatf("t4_port%0d", j), out_port, 3);
      chk($sformatf("t4_data%0d", j), out_data, 8'h50 + 8'(j));
      cyc(1);
    end
    chk("t4_drained", out_valid, 0);
    chk("t4_occ3_empty", occ_of(3), 0);
    push_valid = 4'b1000;
    push_data  = 32'h6000_0000;
    cyc(1);
    push_data  = 32'h6100_0000;
    cyc(1);
    chk("t4_refill0", out_data, 8'h60);
    push_data  = 32'h6200_0000;
    cyc(1);
    chk("t4_refill1", out_data, 8'h61);
    push_valid = '0;
    cyc(1);
    chk("t4_refill2", out_data, 8'h62);
    chk("t4_refill_port", out_port, 3);

    // Illegal multi-hot grant
    do_reset();
    push_valid = 4'b0001;
    push_data  = 32'h0000_0070;
    cyc(1);
    push_valid = '0;
    chk("t5_req", req, 4'b0001);
    force_en  = 1'b1;
    force_gnt = 4'b0011;
    cyc(1);
    chk("t5_err", err, 1);
    chk("t5_occ0", occ_of(0), 1);
    chk("t5_valid", out_valid, 0);
    force_en = 1'b0;
    cyc(1);
    chk("t5_err_sticky", err, 1);
    chk("t5_legal_valid", out_valid, 1);
    chk("t5_legal_data", out_data, 8'h70);

    // Asynchronous reset while busy
    push_valid = 4'b1110;
    push_data  = 32'h8382_8100;
    cyc(1);
    push_valid = '0;
    chk("t6_busy_valid", out_valid, 1);
    chk("t6_busy_occ", occ, 12'b001_001_001_000);
    #2;
    reset_n = 1'b0;
    #1;
    chk("t6_rst_valid", out_valid, 0);
    chk("t6_rst_data", out_data, 0);
    chk("t6_rst_port", out_port, 0);
    chk("t6_rst_err", err, 0);
    chk("t6_rst_req", req, 0);
    chk("t6_rst_pready", push_ready, 4'hF);
    chk("t6_rst_occ", occ, 0);
    @(negedge clk);
    reset_n    = 1'b1;
    out_ready  = 1'b1;
    push_valid = 4'b0001;
    push_data  = 32'h0000_0099;
    cyc(1);
    push_valid = '0;
    chk("t6_req", req, 4'b0001);
    chk("t6_valid_early", out_valid, 0);
    cyc(1);
    chk("t6_valid", out_valid, 1);
    chk("t6_data", out_data, 8'h99);
    chk("t6_port", out_port, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
